// File: rtl/trap_csr_sequencer.sv
// Trap-entry / xRET sequencer that owns the CSR write port while busy.
// Latency: trap = 4 CSR writes + redirect (request N, redirect N+5); return = 1 write + redirect (N+2).
// Backpressure: stall held while busy or a request is pending; requests outside IDLE are dropped.
//
// Ports: clk/rst; trap_valid/cause/pc/tval and ret_req request inputs; live mstatus/mtvec/mepc/sepc
// reads; csr_we/waddr/wdata write port; stall, redirect/redirect_pc and current priv outputs.
module trap_csr_sequencer #(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic [1:0]      ret_req,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] sepc_i,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv
);

    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, R_STATUS, REDIR
    } state_t;

    state_t          state;
    logic [XLEN-1:0] cap_cause;
    logic [XLEN-1:0] cap_tval;
    logic            ret_is_m;
    logic [1:0]      ret_priv;

    logic [XLEN-1:0] trap_status;
    logic [XLEN-1:0] mret_status;
    logic [XLEN-1:0] sret_status;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] tvec_target;

    assign stall = (state != IDLE) | trap_valid | (ret_req == 2'b10) | (ret_req == 2'b01);

    always_comb begin
        trap_status        = mstatus_i;
        trap_status[7]     = mstatus_i[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = priv;

        mret_status        = mstatus_i;
        mret_status[3]     = mstatus_i[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b00;

        sret_status        = mstatus_i;
        sret_status[1]     = mstatus_i[5];
        sret_status[5]     = 1'b1;
        sret_status[8]     = 1'b0;

        // Vectored mode only offsets interrupts; the shift drops the top cause bits by design.
        tvec_base = {mtvec_i[XLEN-1:2], 2'b00};
        if (mtvec_i[1:0] == 2'b01 && cap_cause[XLEN-1])
            tvec_target = tvec_base + {cap_cause[XLEN-3:0], 2'b00};
        else
            tvec_target = tvec_base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            csr_we      <= 1'b0;
            csr_waddr   <= 12'h000;
            csr_wdata   <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            priv        <= RESET_PRIV;
            cap_cause   <= '0;
            cap_tval    <= '0;
            ret_is_m    <= 1'b0;
            ret_priv    <= 2'b00;
        end else begin
            // Strobes default low; address/data hold their last value.
            csr_we   <= 1'b0;
            redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        cap_cause <= trap_cause;
                        cap_tval  <= trap_tval;
                        csr_we    <= 1'b1;
                        csr_waddr <= 12'h341;
                        csr_wdata <= trap_pc;
                        state     <= T_EPC;
                    end else if (ret_req == 2'b10) begin
                        ret_is_m  <= 1'b1;
                        ret_priv  <= mstatus_i[12:11];
                        csr_we    <= 1'b1;
                        csr_waddr <= 12'h300;
                        csr_wdata <= mret_status;
                        state     <= R_STATUS;
                    end else if (ret_req == 2'b01) begin
                        ret_is_m  <= 1'b0;
                        ret_priv  <= {1'b0, mstatus_i[8]};
                        csr_we    <= 1'b1;
                        csr_waddr <= 12'h300;
                        csr_wdata <= sret_status;
                        state     <= R_STATUS;
                    end
                end
                T_EPC: begin
                    csr_we    <= 1'b1;
                    csr_waddr <= 12'h342;
                    csr_wdata <= cap_cause;
                    state     <= T_CAUSE;
                end
                T_CAUSE: begin
                    csr_we    <= 1'b1;
                    csr_waddr <= 12'h343;
                    csr_wdata <= cap_tval;
                    state     <= T_TVAL;
                end
                T_TVAL: begin
                    // MPP records the privilege still current before entry completes.
                    csr_we    <= 1'b1;
                    csr_waddr <= 12'h300;
                    csr_wdata <= trap_status;
                    state     <= T_STATUS;
                end
                T_STATUS: begin
                    priv        <= 2'b11;
                    redirect    <= 1'b1;
                    redirect_pc <= tvec_target;
                    state       <= REDIR;
                end
                R_STATUS: begin
                    priv        <= ret_priv;
                    redirect    <= 1'b1;
                    redirect_pc <= ret_is_m ? mepc_i : sepc_i;
                    state       <= REDIR;
                end
                REDIR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
